// File: rtl/mii_rx_frame_checker_if.sv
// MII receive stream bundle: per-cycle 8-lane data, per-lane control flags and a lane qualifier.
interface mii_rx_frame_checker_if;
  logic        i_valid;
  logic [63:0] i_mii_data;
  logic [7:0]  i_mii_ctrl;

  modport master (output i_valid, output i_mii_data, output i_mii_ctrl);
  modport slave  (input  i_valid, input  i_mii_data, input  i_mii_ctrl);
endinterface

// File: rtl/mii_rx_frame_checker.sv
// MII receive frame checker: delineates frames, checks preamble/control/length, reports per frame.
// Optional FCS checking is enabled by defining MII_RX_CHK_FCS_EN.
module mii_rx_frame_checker #(
  parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
  parameter int unsigned MIN_FRAME_SIZE   = 64
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  mii_rx_frame_checker_if.slave   mii,
  output logic                    o_frame_done,
  output logic                    o_frame_ok,
  output logic [5:0]              o_err_code,
  output logic [15:0]             o_frame_len,
  output logic [47:0]             o_dest_address,
  output logic [47:0]             o_src_address,
  output logic [31:0]             o_good_cnt,
  output logic [31:0]             o_bad_cnt
);
  localparam int unsigned LANES      = 8;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned ERR_W      = 6;
  localparam int unsigned ADDR_BYTES = 12;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned OVERSIZE   = PAYLOAD_MAX_SIZE + 18;

  typedef enum logic {IDLE, DATA} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [ADDR_BYTES*8-1:0] addr_q, addr_d;
  logic                    pre_err_q, pre_err_d;
  logic                    done_q, done_d;
  logic                    ok_q, ok_d;
  logic [ERR_W-1:0]        err_code_q, err_code_d;
  logic [LEN_W-1:0]        frame_len_q, frame_len_d;
  logic [47:0]             dest_q, dest_d;
  logic [47:0]             src_q, src_d;
  logic [CNT_W-1:0]        good_q, good_d;
  logic [CNT_W-1:0]        bad_q, bad_d;

  logic [3:0]              n_bytes;
  logic                    found, ctrl_bad, start_c, pre_bad, fcs_bad;
  logic [LEN_W:0]          len_sum;
  logic [LEN_W-1:0]        acc_len;
  logic [ADDR_BYTES*8-1:0] acc_addr;
  logic [ERR_W-1:0]        fin_err;
  logic [7:0]              byte_v;

`ifdef MII_RX_CHK_FCS_EN
  logic [31:0] crc_q, crc_d, acc_crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    pre_err_d   = pre_err_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    err_code_d  = err_code_q;
    frame_len_d = frame_len_q;
    dest_d      = dest_q;
    src_d       = src_q;
    good_d      = good_q;
    bad_d       = bad_q;
    n_bytes     = 4'd0;
    found       = 1'b0;
    ctrl_bad    = 1'b0;
    byte_v      = 8'h00;
    acc_addr    = addr_q;
`ifdef MII_RX_CHK_FCS_EN
    crc_d       = crc_q;
    acc_crc     = crc_q;
`endif

    start_c = mii.i_mii_ctrl[0] && (mii.i_mii_data[7:0] == 8'hFB);
    pre_bad = (mii.i_mii_ctrl[7:1] != 7'h00) || (mii.i_mii_data[55:8] != {6{8'h55}})
              || (mii.i_mii_data[63:56] != 8'hD5);

    // Frame bytes are the data lanes ahead of the first control lane.
    for (int k = 0; k < LANES; k++) begin
      if (!found) begin
        if (mii.i_mii_ctrl[k]) begin
          found    = 1'b1;
          ctrl_bad = (mii.i_mii_data[8*k +: 8] != 8'hFD);
        end else begin
          n_bytes = n_bytes + 4'd1;
        end
      end
    end

    for (int j = 0; j < LANES; j++) begin
      if (4'(j) < n_bytes) begin
        byte_v = mii.i_mii_data[8*j +: 8];
        for (int b = 0; b < ADDR_BYTES; b++) begin
          if (({1'b0, len_q} + 17'(j)) == 17'(b)) acc_addr[8*b +: 8] = byte_v;
        end
`ifdef MII_RX_CHK_FCS_EN
        acc_crc = crc_byte(acc_crc, byte_v);
`endif
      end
    end

    len_sum = {1'b0, len_q} + 17'(n_bytes);
    acc_len = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];

`ifdef MII_RX_CHK_FCS_EN
    fcs_bad = (acc_crc != 32'hDEBB20E3);
`else
    fcs_bad = 1'b0;
`endif

    fin_err = {start_c, fcs_bad, acc_len > 16'(OVERSIZE), acc_len < 16'(MIN_FRAME_SIZE),
               ctrl_bad & ~start_c, pre_err_q};

    if (mii.i_valid) begin
      if ((state_q == DATA) && (start_c || found)) begin
        done_d      = 1'b1;
        err_code_d  = fin_err;
        ok_d        = (fin_err == 6'd0);
        frame_len_d = acc_len;
        dest_d      = {acc_addr[7:0], acc_addr[15:8], acc_addr[23:16],
                       acc_addr[31:24], acc_addr[39:32], acc_addr[47:40]};
        src_d       = {acc_addr[55:48], acc_addr[63:56], acc_addr[71:64],
                       acc_addr[79:72], acc_addr[87:80], acc_addr[95:88]};
        if (fin_err == 6'd0) good_d = good_q + 32'd1;
        else                 bad_d  = bad_q + 32'd1;
      end

      // A start opens a new frame from either state; an abort restarts in place.
      if (start_c) begin
        state_d   = DATA;
        len_d     = '0;
        addr_d    = '0;
        pre_err_d = pre_bad;
`ifdef MII_RX_CHK_FCS_EN
        crc_d     = 32'hFFFFFFFF;
`endif
      end else if (state_q == DATA) begin
        if (found) begin
          state_d = IDLE;
        end else begin
          len_d  = acc_len;
          addr_d = acc_addr;
`ifdef MII_RX_CHK_FCS_EN
          crc_d  = acc_crc;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      pre_err_q   <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_code_q  <= '0;
      frame_len_q <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
`ifdef MII_RX_CHK_FCS_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      pre_err_q   <= pre_err_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_code_q  <= err_code_d;
      frame_len_q <= frame_len_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
`ifdef MII_RX_CHK_FCS_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign o_frame_done   = done_q;
  assign o_frame_ok     = ok_q;
  assign o_err_code     = err_code_q;
  assign o_frame_len    = frame_len_q;
  assign o_dest_address = dest_q;
  assign o_src_address  = src_q;
  assign o_good_cnt     = good_q;
  assign o_bad_cnt      = bad_q;
endmodule

// File: tb/tb_mii_rx_frame_checker.sv
// Bench for mii_rx_frame_checker: frames are encoded onto the MII stream and results
// are predicted from frame-level rules (length, ending character, preamble, FCS).
module tb_mii_rx_frame_checker;
  localparam int unsigned PMAX = 1500;
  localparam int unsigned MINF = 64;

  typedef struct {
    logic [15:0] len;
    logic [5:0]  err;
    logic [47:0] d;
    logic [47:0] s;
  } res_t;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        o_frame_done, o_frame_ok;
  logic [5:0]  o_err_code;
  logic [15:0] o_frame_len;
  logic [47:0] o_dest_address, o_src_address;
  logic [31:0] o_good_cnt, o_bad_cnt;

  mii_rx_frame_checker_if bus ();

  mii_rx_frame_checker #(.PAYLOAD_MAX_SIZE(PMAX), .MIN_FRAME_SIZE(MINF)) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .mii            (bus.slave),
    .o_frame_done   (o_frame_done),
    .o_frame_ok     (o_frame_ok),
    .o_err_code     (o_err_code),
    .o_frame_len    (o_frame_len),
    .o_dest_address (o_dest_address),
    .o_src_address  (o_src_address),
    .o_good_cnt     (o_good_cnt),
    .o_bad_cnt      (o_bad_cnt)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  frm[$];
  logic [8:0]  chq[$];
  bit          endq[$];
  res_t        expq[$];
  bit          pending_abort = 1'b0;
  bit          prev_end = 1'b0;
  logic [31:0] good_m = 0, bad_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Textbook Ethernet CRC (the transmitted FCS value).
  function automatic logic [31:0] crc_of(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int len, input logic [47:0] d, input logic [47:0] s);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(s[47-8*i -: 8]);
    for (int i = 0; i < len - 16; i++) frm.push_back(8'($urandom));
    f = crc_of(frm, frm.size());
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
  endtask

  task automatic push_ch(input logic [8:0] ch, input bit e);
    chq.push_back(ch);
    endq.push_back(e);
  endtask

  // end_kind: 0 terminate, 1 error char after fe_pos bytes, 2 aborted by the next start
  task automatic push_frame(input int pre_lane, input int end_kind, input int fe_pos);
    logic [7:0] rx[$];
    res_t       r;
    int         n;
    bit         fcs_ok;
    push_ch(9'h1FB, pending_abort);
    pending_abort = 1'b0;
    for (int k = 1; k <= 6; k++) push_ch({1'b0, (k == pre_lane) ? 8'h54 : 8'h55}, 1'b0);
    push_ch(9'h0D5, 1'b0);
    n = (end_kind == 1) ? fe_pos : frm.size();
    for (int i = 0; i < n; i++) begin
      push_ch({1'b0, frm[i]}, 1'b0);
      rx.push_back(frm[i]);
    end
    if (end_kind == 0)      push_ch(9'h1FD, 1'b1);
    else if (end_kind == 1) push_ch(9'h1FE, 1'b1);
    else                    pending_abort = 1'b1;
    while (chq.size() % 8 != 0) push_ch(9'h107, 1'b0);
    r.len = 16'(n);
    r.d = '0;
    r.s = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < n)     r.d[47-8*i -: 8] = rx[i];
      if (i + 6 < n) r.s[47-8*i -: 8] = rx[i+6];
    end
    fcs_ok = (n >= 4) && (crc_of(rx, n - 4) == {rx[n-1], rx[n-2], rx[n-3], rx[n-4]});
`ifndef MII_RX_CHK_FCS_EN
    fcs_ok = 1'b1;
`endif
    r.err = {end_kind == 2, !fcs_ok, n > int'(PMAX + 18), n < int'(MINF), end_kind == 1, pre_lane != 0};
    expq.push_back(r);
  endtask

  task automatic check_cycle();
    res_t r;
    chk("done", 64'(o_frame_done), 64'(prev_end));
    if (prev_end) begin
      chk("exp_avail", 64'(expq.size() > 0), 64'd1);
      if (expq.size() > 0) begin
        r = expq.pop_front();
        if (r.err == 6'd0) good_m++;
        else               bad_m++;
        chk("ok",   64'(o_frame_ok), 64'(r.err == 6'd0));
        chk("err",  64'(o_err_code), 64'(r.err));
        chk("len",  64'(o_frame_len), 64'(r.len));
        chk("dest", 64'(o_dest_address), 64'(r.d));
        chk("src",  64'(o_src_address), 64'(r.s));
      end
    end
    chk("good_cnt", 64'(o_good_cnt), 64'(good_m));
    chk("bad_cnt",  64'(o_bad_cnt), 64'(bad_m));
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic [7:0] c, input bit e);
    @(negedge clk);
    check_cycle();
    bus.i_valid    = v;
    bus.i_mii_data = d;
    bus.i_mii_ctrl = c;
    prev_end       = v && e;
  endtask

  task automatic run(input int gap_pct);
    logic [63:0] d;
    logic [7:0]  c;
    bit          e;
    logic [8:0]  ch;
    while (chq.size() > 0) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        step(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b1);
      end else begin
        e = 1'b0;
        for (int k = 0; k < 8; k++) begin
          ch = chq.pop_front();
          e  = e | endq.pop_front();
          d[8*k +: 8] = ch[7:0];
          c[k]        = ch[8];
        end
        step(1'b1, d, c, e);
      end
    end
    repeat (2) step(1'b1, {8{8'h07}}, 8'hFF, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, 64'(o_frame_done), 64'd0);
    chk({tag, "_ok"},   64'(o_frame_ok), 64'd0);
    chk({tag, "_err"},  64'(o_err_code), 64'd0);
    chk({tag, "_len"},  64'(o_frame_len), 64'd0);
    chk({tag, "_dest"}, 64'(o_dest_address), 64'd0);
    chk({tag, "_src"},  64'(o_src_address), 64'd0);
    chk({tag, "_good"}, 64'(o_good_cnt), 64'd0);
    chk({tag, "_bad"},  64'(o_bad_cnt), 64'd0);
  endtask

  initial begin
    bus.i_valid    = 1'b0;
    bus.i_mii_data = '0;
    bus.i_mii_ctrl = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;

    // Reference frame, then the same frame with a payload byte flipped
    build_frame(64, 48'h0A0B0C0D0E0F, 48'h112233445566);
    push_frame(0, 0, 0);
    run(0);
    build_frame(64, 48'h0A0B0C0D0E0F, 48'h112233445566);
    frm[30] = frm[30] ^ 8'h40;
    push_frame(0, 0, 0);
    run(0);

    // Terminate lane sweep with stalls
    for (int l = 64; l <= 71; l++) begin
      build_frame(l, {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)});
      push_frame(0, 0, 0);
      run(30);
    end

    // Error cases: preamble, runt, oversize, error character
    build_frame(64, 48'h010203040506, 48'h0708090A0B0C);
    push_frame(3, 0, 0);
    run(10);
    build_frame(60, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6);
    push_frame(0, 0, 0);
    run(10);
    build_frame(1520, 48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6);
    push_frame(0, 0, 0);
    run(5);
    build_frame(100, 48'hE1E2E3E4E5E6, 48'hF1F2F3F4F5F6);
    push_frame(0, 1, 66);
    run(10);

    // Abort by a new start, then back-to-back frames without idle cycles
    build_frame(64, 48'h111111111111, 48'h222222222222);
    push_frame(0, 2, 0);
    build_frame(70, 48'h333333333333, 48'h444444444444);
    push_frame(0, 0, 0);
    build_frame(71, 48'h555555555555, 48'h666666666666);
    push_frame(0, 0, 0);
    build_frame(64, 48'h777777777777, 48'h888888888888);
    push_frame(0, 0, 0);
    run(0);

    // Random frames
    for (int i = 0; i < 6; i++) begin
      build_frame(int'($urandom_range(64, 200)), {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)});
      push_frame(0, 0, 0);
      run(20);
    end

    // Reset in the middle of a frame discards it
    step(1'b1, {8'hD5, {6{8'h55}}, 8'hFB}, 8'h01, 1'b0);
    step(1'b1, {$urandom, $urandom}, 8'h00, 1'b0);
    step(1'b1, {$urandom, $urandom}, 8'h00, 1'b0);
    @(negedge clk);
    check_cycle();
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    good_m   = 0;
    bad_m    = 0;
    prev_end = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    i_rst_n     = 1'b1;
    build_frame(64, 48'h0A0B0C0D0E0F, 48'h112233445566);
    push_frame(0, 0, 0);
    run(0);

    chk("leftover", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
